// File: rtl/freq_range_ctrl.sv
// freq_range_ctrl
//   Measurement scheduler and auto-ranging controller for the frequency meter.
//   Runs a repeating CLEAR -> GATE -> LATCH cycle, counts rising edges of the
//   synchronised test signal while the gate is open, and publishes a 0..CNT_MAX
//   result together with the range flag. In auto mode the range moves up on
//   overflow in the low range and down on a tiny count in the high range.
//
// Ports
//   sysclk        in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   sigin         in   signal under test (asynchronous)
//   automode      in   1 = auto-ranging, 0 = manual
//   modecontrol   in   manual range select (1 = high/kHz, 0 = low/Hz)
//   hold          in   (FREQ_HOLD_EN only) freeze published result when 1
//   highfreq      out  current range (1 = high/kHz)
//   result[13:0]  out  last accepted measurement
//   result_valid  out  one-cycle pulse when result/overflow update
//   overflow      out  last accepted measurement saturated
//   gate          out  high while the gate window is open
//
// Optional feature: define FREQ_HOLD_EN to add the hold input.
module freq_range_ctrl #(
    parameter int unsigned GATE_LO_CYC = 100_000_000,
    parameter int unsigned GATE_HI_CYC = 100_000,
    parameter int unsigned CNT_MAX     = 9999,
    parameter int unsigned DOWN_THR    = 10
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        sigin,
    input  logic        automode,
    input  logic        modecontrol,
`ifdef FREQ_HOLD_EN
    input  logic        hold,
`endif
    output logic        highfreq,
    output logic [13:0] result,
    output logic        result_valid,
    output logic        overflow,
    output logic        gate
);

    localparam int unsigned GateMax = (GATE_LO_CYC > GATE_HI_CYC) ? GATE_LO_CYC : GATE_HI_CYC;
    localparam int unsigned TimerW  = $clog2(GateMax);

    localparam logic [TimerW-1:0] LoLoad  = TimerW'(GATE_LO_CYC - 1);
    localparam logic [TimerW-1:0] HiLoad  = TimerW'(GATE_HI_CYC - 1);
    localparam logic [13:0]       CntMax  = 14'(CNT_MAX);
    localparam logic [13:0]       CntSat  = 14'(CNT_MAX + 1);
    localparam logic [13:0]       DownThr = 14'(DOWN_THR);

    typedef enum logic [1:0] {StClear, StGate, StLatch} state_e;

    state_e            state_q, state_d;
    logic [2:0]        sync_q, sync_d;
    logic [13:0]       cnt_q, cnt_d;
    logic [13:0]       result_q, result_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              auto_q, auto_d;
    logic              highfreq_q, highfreq_d;
    logic              overflow_q, overflow_d;
    logic              valid_q, valid_d;

    logic edge_det, clear_hi, over, switch_up, switch_dn, hold_now;

`ifdef FREQ_HOLD_EN
    assign hold_now = hold;
`else
    assign hold_now = 1'b0;
`endif

    // sync_q[1] is the synchronised signal, sync_q[2] its previous value
    assign edge_det  = sync_q[1] & ~sync_q[2];
    // Range for the gate about to start: manual mode takes modecontrol now
    assign clear_hi  = automode ? highfreq_q : modecontrol;
    assign over      = (cnt_q > CntMax);
    // Auto range switches consume the measurement without publishing it
    assign switch_up = auto_q & ~highfreq_q & over;
    assign switch_dn = auto_q & highfreq_q & (cnt_q < DownThr);

    // State register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: state_d = StGate;
            StGate:  if (timer_q == '0) state_d = StLatch;
            StLatch: state_d = StClear;
            default: state_d = StClear;
        endcase
    end

    // Output logic
    always_comb begin
        gate = (state_q == StGate);
    end

    // Datapath next-state
    always_comb begin
        sync_d     = {sync_q[1:0], sigin};
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        auto_d     = auto_q;
        highfreq_d = highfreq_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        unique case (state_q)
            StClear: begin
                cnt_d      = '0;
                auto_d     = automode;
                highfreq_d = clear_hi;
                timer_d    = clear_hi ? HiLoad : LoLoad;
            end
            StGate: begin
                if (timer_q != '0) timer_d = timer_q - TimerW'(1);
                if (edge_det && (cnt_q != CntSat)) cnt_d = cnt_q + 14'd1;
            end
            StLatch: begin
                if (switch_up) begin
                    highfreq_d = 1'b1;
                end else if (switch_dn) begin
                    highfreq_d = 1'b0;
                end
                if (!switch_up && !switch_dn && !hold_now) begin
                    result_d   = over ? CntMax : cnt_q;
                    overflow_d = over;
                    valid_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            auto_q     <= 1'b0;
            highfreq_q <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            auto_q     <= auto_d;
            highfreq_q <= highfreq_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign highfreq     = highfreq_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_freq_range_ctrl.sv
// Bench for freq_range_ctrl with shortened gates. The reference model works on
// the measurement schedule (CLEAR cycle index, gate length) and counts rising
// edges of the recorded sigin history inside each gate window.
module tb_freq_range_ctrl;

    localparam int GL     = 2000;
    localparam int GH     = 20;
    localparam int CMAX   = 499;
    localparam int DTHR   = 5;
    localparam int MAXCYC = 90000;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        sigin = 1'b0;
    logic        automode = 1'b1;
    logic        modecontrol = 1'b0;
`ifdef FREQ_HOLD_EN
    logic        hold = 1'b0;
`endif
    logic        highfreq, result_valid, overflow, gate;
    logic [13:0] result;

    always #5 sysclk = ~sysclk;

    freq_range_ctrl #(
        .GATE_LO_CYC (GL),
        .GATE_HI_CYC (GH),
        .CNT_MAX     (CMAX),
        .DOWN_THR    (DTHR)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .sigin        (sigin),
        .automode     (automode),
        .modecontrol  (modecontrol),
`ifdef FREQ_HOLD_EN
        .hold         (hold),
`endif
        .highfreq     (highfreq),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow),
        .gate         (gate)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit sig_hist [MAXCYC];
    int sig_per = 40;
    int sig_high = 20;
    int sig_ph = 0;

    // Reference model state
    int m_start = 0;  // cycle index of the current CLEAR
    int m_rel = 0;    // first cycle after the last reset edge
    int m_len = 0;    // gate length of the current measurement
    bit m_auto = 1'b0;
    bit m_hf = 1'b0;
    bit m_ovf = 1'b0;
    bit m_val = 1'b0;
    bit m_gate = 1'b0;
    int m_res = 0;
    int n_latch = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int got, input int lo, input int hi);
        n_cmp++;
        if (got < lo || got > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
        end
    endtask

    task automatic print_summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // Rising edges of sigin driven in cycles lo..hi; history before m_rel was
    // swallowed by reset, so the first kept sample sees a 0 predecessor.
    function automatic int count_edges(input int lo, input int hi);
        int c;
        bit prev;
        c = 0;
        for (int s = lo; s <= hi; s++) begin
            prev = (s > m_rel) ? sig_hist[s-1] : 1'b0;
            if (sig_hist[s] && !prev) c++;
        end
        return c;
    endfunction

    task automatic publish(input int r, input bit o);
`ifdef FREQ_HOLD_EN
        if (hold) return;
`endif
        m_res = r;
        m_ovf = o;
        m_val = 1'b1;
    endtask

    task automatic latch_eval(input int t);
        int lo, c;
        bit ov;
        lo = (m_start - 1 > m_rel) ? m_start - 1 : m_rel;
        // An edge driven in cycle s is counted if cycle s+2 lies in the gate
        c  = count_edges(lo, m_start + m_len - 2);
        if (c > CMAX + 1) c = CMAX + 1;
        ov = (c > CMAX);
        if (!m_auto)              publish(ov ? CMAX : c, ov);
        else if (!m_hf && ov)     m_hf = 1'b1;
        else if (m_hf && c < DTHR) m_hf = 1'b0;
        else if (ov)              publish(CMAX, 1'b1);
        else                      publish(c, 1'b0);
        m_start = t;
        n_latch++;
    endtask

    // Effect of the clock edge that began cycle t, using the inputs of cycle t-1
    task automatic model_update();
        int t;
        t = cyc;
        if (rst) begin
            m_start = t;
            m_rel   = t;
            m_len   = 0;
            m_hf    = 1'b0;
            m_res   = 0;
            m_ovf   = 1'b0;
            m_val   = 1'b0;
            cmp_en  = 1'b1;
        end else begin
            m_val = 1'b0;
            if (t - 1 == m_start) begin
                m_auto = automode;
                if (!automode) m_hf = modecontrol;
                m_len = m_hf ? GH : GL;
            end else if (t - 1 == m_start + m_len + 1) begin
                latch_eval(t);
            end
        end
        m_gate = (t > m_start) && (t <= m_start + m_len);
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
        cyc++;
        if (cyc >= MAXCYC) begin
            n_bad++;
            $display("FAIL cycle_budget: got %0d cycles, required < %0d", cyc, MAXCYC);
            print_summary();
            $fatal(1, "cycle budget exhausted");
        end
        model_update();
        sigin = (sig_ph < sig_high);
        sig_ph = (sig_ph + 1) % sig_per;
        sig_hist[cyc] = sigin;
    endtask

    task automatic set_sig(input int per, input int high);
        sig_per  = per;
        sig_high = high;
        sig_ph   = 0;
    endtask

    task automatic run_latches(input int n);
        int target, budget;
        target = n_latch + n;
        budget = n * (GL + 2) * 2 + 50;
        while (n_latch < target && budget > 0) begin
            step();
            budget--;
        end
        if (n_latch < target) chk("latch_timeout", n_latch, target, target);
    endtask

    task automatic wait_valid(input int r, input string name);
        int budget;
        budget = 3 * GL;
        while (!result_valid && budget > 0) begin
            step();
            budget--;
        end
        chk(name, cyc - r, GL + 2, GL + 2);
    endtask

    task automatic cmp_out(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL cmp_%s cycle %0d: got %0d, required %0d", name, cyc, got, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (cmp_en) begin
            cmp_out("gate", int'(gate), int'(m_gate));
            cmp_out("highfreq", int'(highfreq), int'(m_hf));
            cmp_out("result", int'(result), m_res);
            cmp_out("overflow", int'(overflow), int'(m_ovf));
            cmp_out("result_valid", int'(result_valid), int'(m_val));
        end
    end

    initial begin
        int r, p;

        // Reset, then auto mode at period 40: 2000/40 = 50 edges per low gate
        set_sig(40, 20);
        step();
        step();
        chk("rst_result", int'(result), 0, 0);
        chk("rst_gate", int'(gate), 0, 0);
        chk("rst_highfreq", int'(highfreq), 0, 0);
        chk("rst_valid", int'(result_valid), 0, 0);
        chk("rst_overflow", int'(overflow), 0, 0);
        rst = 1'b0;
        r = cyc;
        wait_valid(r, "first_valid_latency");
        chk("p40_model_result", m_res, 49, 51);
        chk("p40_dut_result", int'(result), 49, 51);
        chk("p40_highfreq", int'(highfreq), 0, 0);
        run_latches(1);
        chk("p40_overflow", int'(overflow), 0, 0);

        // Period 2 saturates the low range: step up without publishing
        set_sig(2, 1);
        run_latches(1);
        chk("up_model_hf", int'(m_hf), 1, 1);
        chk("up_dut_hf", int'(highfreq), 1, 1);
        chk("up_no_valid", int'(result_valid), 0, 0);
        run_latches(1);
        chk("hi_model_result", m_res, 9, 11);
        chk("hi_dut_result", int'(result), 9, 11);

        // Period 400 in the high range gives < DOWN_THR: step down
        set_sig(400, 200);
        run_latches(1);
        chk("down_model_hf", int'(m_hf), 0, 0);
        chk("down_dut_hf", int'(highfreq), 0, 0);
        run_latches(1);
        chk("p400_model_result", m_res, 4, 6);

        // Manual low range, fast signal: saturated result with overflow
        automode = 1'b0;
        modecontrol = 1'b0;
        set_sig(2, 1);
        run_latches(1);
        chk("man_model_result", m_res, CMAX, CMAX);
        chk("man_model_ovf", int'(m_ovf), 1, 1);
        chk("man_dut_result", int'(result), CMAX, CMAX);
        chk("man_dut_hf", int'(highfreq), 0, 0);
        repeat (50) step();
        modecontrol = 1'b1;
        run_latches(1);
        chk("man_midgate_hf", int'(highfreq), 0, 0);
        run_latches(1);
        chk("man_hi_result", m_res, 9, 11);
        chk("man_hi_ovf", int'(overflow), 0, 0);
        chk("man_hi_hf", int'(highfreq), 1, 1);

        // Reset in the middle of a measurement
        automode = 1'b1;
        set_sig(40, 20);
        repeat (100) step();
        rst = 1'b1;
        step();
        chk("midrst_result", int'(result), 0, 0);
        chk("midrst_hf", int'(highfreq), 0, 0);
        chk("midrst_gate", int'(gate), 0, 0);
        chk("midrst_ovf", int'(overflow), 0, 0);
        rst = 1'b0;
        r = cyc;
        wait_valid(r, "midrst_valid_latency");
        chk("midrst_new_result", int'(result), 49, 51);

        // Randomised modes and signal shapes, checked against the model
        for (int i = 0; i < 6; i++) begin
            automode = ($urandom_range(0, 3) != 0);
            modecontrol = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 5))
                                            : int'($urandom_range(6, 500));
            set_sig(p, int'($urandom_range(1, p - 1)));
            repeat ($urandom_range(0, 30)) step();
            run_latches(1);
        end

`ifdef FREQ_HOLD_EN
        automode = 1'b1;
        set_sig(40, 20);
        run_latches(2);
        chk("hold_pre_result", m_res, 49, 51);
        hold = 1'b1;
        set_sig(80, 40);
        run_latches(2);
        chk("hold_model_result", m_res, 49, 51);
        chk("hold_dut_result", int'(result), 49, 51);
        hold = 1'b0;
        run_latches(1);
        chk("hold_release_result", m_res, 24, 26);
        chk("hold_release_valid", int'(result_valid), 1, 1);
`endif

        cmp_en = 1'b0;
        print_summary();
        $finish;
    end

endmodule

// File: doc/freq_range_ctrl.md
Name: freq_range_ctrl

Overview:
- Measurement scheduler and auto-ranging controller for the frequency-meter datapath.
- Sequences clear/gate/latch windows over the test signal and counts rising edges per gate.
- Selects the low range (Hz, long gate) or the high range (kHz, short gate), either automatically or from modecontrol.
- Delivers a latched 0–9999 result plus range flag to the display path.

Parameters:
- GATE_LO_CYC, 100_000_000: sysclk cycles per low-range gate (1 s at 100 MHz; result in Hz).
- GATE_HI_CYC, 100_000: sysclk cycles per high-range gate (1 ms at 100 MHz; result in kHz).
- CNT_MAX, 9999: largest displayable result; the edge counter saturates at CNT_MAX+1.
- DOWN_THR, 10: in auto high range, a result below this switches to low range.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sigin  in  1  signal under test; asynchronous to sysclk.
- automode  in  1  1 = auto-ranging; 0 = manual range.
- modecontrol  in  1  manual range select, used only when automode=0: 1 = high, 0 = low.
- highfreq  out  1  current range: 1 = high/kHz, 0 = low/Hz.
- result  out  14  last accepted measurement, binary, 0..CNT_MAX.
- result_valid  out  1  one-cycle pulse when result/overflow update.
- overflow  out  1  last accepted measurement saturated.
- gate  out  1  high while the gate window is open.

Behaviour:
- Reset state:
  - highfreq=0, result=0, result_valid=0, overflow=0, gate=0.
  - FSM=CLEAR, edge counter=0, gate timer=0, synchroniser flops=0.
- Reset mid-operation discards the measurement in progress; the first result_valid comes exactly GATE_LO_CYC+2 cycles after the first cycle with rst=0.
- Input conditioning:
  - sigin passes a 2-FF synchroniser followed by a rising-edge detector (1 pulse per 0→1 of the synchronised signal).
  - Edge latency is 3 cycles.
  - Supported sigin has high and low phases of at least 1 sysclk cycle each.
- FSM, 3 states:
  - CLEAR (1 cycle): edge counter←0. Samples automode/modecontrol. Manual mode: highfreq←modecontrol. Gate timer←GATE_HI_CYC-1 if the range is high, else GATE_LO_CYC-1. →GATE.
  - GATE (exactly GATE_x cycles): gate=1. Each detected edge increments the edge counter, saturating at CNT_MAX+1. Timer counts down; when it reaches 0 →LATCH.
  - LATCH (1 cycle): evaluate the count (rules below). →CLEAR.
- Edges detected in CLEAR or LATCH cycles are dropped.
- Measurement period is GATE_x+2 cycles.
- Evaluation in LATCH (results register at the edge ending LATCH; result_valid is high for the following single cycle):
  - Manual: result←min(count, CNT_MAX); overflow←(count>CNT_MAX); pulse valid.
  - Auto, low range, count>CNT_MAX: highfreq←1; result and overflow unchanged; no valid pulse.
  - Auto, high range, count<DOWN_THR: highfreq←0; result unchanged; no valid pulse.
  - Auto, high range, count>CNT_MAX: result←CNT_MAX; overflow←1; pulse valid; range stays high.
  - Auto, otherwise: result←count; overflow←0; pulse valid.
- Changes on automode/modecontrol mid-gate take effect only at the next CLEAR.
- Switching from auto to manual sets the range from modecontrol at CLEAR.
- At most one range change per measurement; no oscillation for a steady input, given the hysteresis between CNT_MAX and DOWN_THR.

Optional Feature:
- Macro FREQ_HOLD_EN.
- When defined:
  - Adds input port hold (1 bit), sampled in LATCH.
  - If hold=1, result/overflow do not update and result_valid is suppressed.
  - Measurements and auto-range switching continue unaffected.
- When undefined: the port does not exist and results always update as above.

Test Plan:
- Params GATE_LO_CYC=100000, GATE_HI_CYC=100. Auto, sigin period 40 cycles → result=2500±1, highfreq=0, overflow=0; result_valid every 100002 cycles; first valid 100002 cycles after reset release.
- Auto, sigin period 4 → first LATCH count saturates: highfreq→1, no valid. Next measurement 102 cycles later: result=25±1, valid pulse, highfreq=1.
- From the previous state, sigin period 400 → high-range count 0 (<10): highfreq→0, no valid. Next low-range measurement: result=250±1.
- Manual (automode=0, modecontrol=0), sigin period 4 → result=9999, overflow=1, valid pulse, highfreq stays 0. Then modecontrol=1 mid-gate → highfreq changes only at the next CLEAR; next result=25, overflow=0.
- rst asserted for 1 cycle mid-GATE → next cycle: all outputs 0, gate=0; new measurement restarts; first valid GATE_LO_CYC+2 cycles after release.
- FREQ_HOLD_EN defined: hold=1 across two LATCHes with period changing 40→80 → result stays 2500, no valid pulses. hold=0 → next result=1250±1 with valid.
